// File: rtl/switch_debounce.sv
// switch_debounce
// Synchronizes a bank of raw, bouncing switch lines into the clk domain and
// debounces them as one vector. A new vector value is accepted only after the
// synchronized input has held unchanged for DEBOUNCE_CYCLES clocks. On
// acceptance the clean vector is updated in one step, and a one-cycle
// 'changed' pulse is issued.
//
// Build option: define SWITCH_DEBOUNCE_IRQ_EN to add the read_n / ce_n / irq_n
// ports. These ports provide a sticky change interrupt that a bus read of the
// switch controller clears.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_sw,
  output logic [WIDTH-1:0] switches,
  output logic             changed
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  ,
  input  logic             read_n,
  input  logic             ce_n,
  output logic             irq_n
`endif
);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  // Synchronizer chain: element 0 samples the pins, and the last element is
  // the first value that is safe to use in the clk domain.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic             changed_q, changed_d;

  // Plain flop-to-flop shift chain, with no logic between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_sw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // State, candidate, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
    end
  end

  // Next-state logic. In SETTLING, a bounce (sync differs from the candidate)
  // restarts the full window. When the window expires, the candidate is
  // committed only if it differs from the current output. An input that
  // bounces back to the original value therefore settles without a pulse.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    sw_d      = sw_q;
    changed_d = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync != sw_q) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (sync != cand_q) begin
          cand_d = sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          if (cand_q != sw_q) begin
            sw_d      = cand_q;
            changed_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign switches = sw_q;
  assign changed  = changed_q;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic irq_n_q, irq_n_d;
  logic bus_read;

  assign bus_read = ~ce_n & ~read_n;

  // Sticky flag, held active low. It is set by a change pulse and cleared by
  // a bus read. If both happen in the same cycle, the set wins so the change
  // is not lost.
  always_comb begin
    irq_n_d = irq_n_q;
    if (changed_q) begin
      irq_n_d = 1'b0;
    end else if (bus_read) begin
      irq_n_d = 1'b1;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_n_q <= 1'b1;
    end else begin
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce, with WIDTH=8, SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=4. A behavioural reference model predicts the outputs after
// every clock edge. The model treats the pins as seen SYNC edges late, and it
// accepts a value once the FSM has observed that value for DEB+1 consecutive
// edges while it differs from the current output.
module tb_switch_debounce;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_sw;
  logic [W-1:0] switches;
  logic         changed;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic         read_n;
  logic         ce_n;
  logic         irq_n;
`endif

  switch_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_sw  (raw_sw),
    .switches(switches),
    .changed (changed)
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    ,
    .read_n  (read_n),
    .ce_n    (ce_n),
    .irq_n   (irq_n)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;
  int pulse_count = 0;
  int last_pulse_edge = -1000;

  // Reference model state.
  logic [W-1:0] hist [SYNC];
  logic [W-1:0] m_sw     = '0;
  logic         m_chg    = 1'b0;
  logic         m_irq_n  = 1'b1;
  logic [W-1:0] last_s   = '0;
  int           run_len  = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, then compare.
  task automatic cycle(input logic [W-1:0] raw, input logic rst,
                       input logic rd_n_v, input logic ce_n_v);
    logic [W-1:0] s;
    logic         nirq;
    raw_sw = raw;
    reset  = rst;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    read_n = rd_n_v;
    ce_n   = ce_n_v;
`endif
    @(posedge clk);
    edge_no++;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
      m_sw    = '0;
      m_chg   = 1'b0;
      m_irq_n = 1'b1;
      last_s  = '0;
      run_len = 1;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      if (s == last_s) begin
        run_len++;
      end else begin
        last_s  = s;
        run_len = 1;
      end
      nirq = m_chg ? 1'b0 : ((!rd_n_v && !ce_n_v) ? 1'b1 : m_irq_n);
      m_chg = 1'b0;
      if (s != m_sw && run_len == DEB + 1) begin
        m_sw  = s;
        m_chg = 1'b1;
      end
      m_irq_n = nirq;
    end
    #1;
    $display("edge %0d rst=%0b raw=%02h -> switches=%02h changed=%0b", edge_no, rst, raw, switches, changed);
    chk("switches", 32'(switches), 32'(m_sw));
    chk("changed", 32'(changed), 32'(m_chg));
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    chk("irq_n", 32'(irq_n), 32'(m_irq_n));
`endif
    if (changed) begin
      pulse_count++;
      last_pulse_edge = edge_no;
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b0, 1'b1, 1'b1);
  endtask

  logic [W-1:0] tbl [4];
  logic [W-1:0] prev_v, v;

  initial begin
    int k0, pc0, t_last, n;
    tbl[0] = 8'h00; tbl[1] = 8'h5A; tbl[2] = 8'h5B; tbl[3] = 8'hFF;
    for (int i = 0; i < SYNC; i++) hist[i] = '0;
    raw_sw = '0;
    reset  = 1'b1;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    read_n = 1'b1;
    ce_n   = 1'b1;
`endif
    @(negedge clk);

    // Reset, then idle with all pins low.
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, 1'b1, 1'b1);
    chk("rst_switches", 32'(switches), 32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
    pc0 = pulse_count;
    hold(8'h00, 20);
    chk("idle_pulses", 32'(pulse_count - pc0), 32'd0);

    // Clean change: commit exactly SYNC+DEB edges after the pins change.
    k0 = edge_no + 1;
    pc0 = pulse_count;
    hold(8'hA5, 12);
    chk("a5_latency", 32'(last_pulse_edge - k0), 32'(SYNC + DEB));
    chk("a5_pulses", 32'(pulse_count - pc0), 32'd1);
    chk("a5_value", 32'(switches), 32'hA5);

    // Toggle every 2 cycles: never commits, then commits after the final hold.
    hold(8'h00, 10);
    pc0 = pulse_count;
    prev_v = 8'h00;
    t_last = edge_no;
    for (int i = 0; i < 40; i++) begin
      v = ((i / 2) % 2 == 1) ? 8'h01 : 8'h00;
      if (v != prev_v) t_last = edge_no + 1;
      prev_v = v;
      cycle(v, 1'b0, 1'b1, 1'b1);
    end
    chk("toggle_no_commit", 32'(pulse_count - pc0), 32'd0);
    pc0 = pulse_count;
    hold(8'h01, 12);
    chk("toggle_latency", 32'(last_pulse_edge - t_last), 32'(SYNC + DEB));
    chk("toggle_pulses", 32'(pulse_count - pc0), 32'd1);
    chk("toggle_value", 32'(switches), 32'h01);

    // Short glitch that bounces back to the original value.
    hold(8'h00, 10);
    pc0 = pulse_count;
    hold(8'h0F, 2);
    hold(8'h00, 20);
    chk("glitch_pulses", 32'(pulse_count - pc0), 32'd0);
    chk("glitch_value", 32'(switches), 32'h00);

    // Reset during a settle (counter at 2), then release with 3C still held.
    pc0 = pulse_count;
    hold(8'h3C, 5);
    cycle(8'h3C, 1'b1, 1'b1, 1'b1);
    cycle(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("midrst_switches", 32'(switches), 32'h0);
    chk("midrst_pulses", 32'(pulse_count - pc0), 32'd0);
    k0 = edge_no + 1;
    hold(8'h3C, 12);
    chk("midrst_latency", 32'(last_pulse_edge - k0), 32'(SYNC + DEB));
    chk("midrst_value", 32'(switches), 32'h3C);

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    // Read coinciding with the change pulse: set wins.
    n = 0;
    cycle(8'h81, 1'b0, 1'b1, 1'b1);
    while (!changed && n < 20) begin
      cycle(8'h81, 1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("irq_pulse_seen", 32'(changed), 32'h1);
    cycle(8'h81, 1'b0, 1'b0, 1'b0);
    chk("irq_set_wins", 32'(irq_n), 32'h0);
    cycle(8'h81, 1'b0, 1'b1, 1'b1);
    chk("irq_sticky", 32'(irq_n), 32'h0);
    cycle(8'h81, 1'b0, 1'b0, 1'b0);
    chk("irq_clear", 32'(irq_n), 32'h1);
    // Plain change: the flag sets on the edge after the pulse.
    n = 0;
    cycle(8'h18, 1'b0, 1'b1, 1'b1);
    while (!changed && n < 20) begin
      cycle(8'h18, 1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("irq_pulse2_seen", 32'(changed), 32'h1);
    cycle(8'h18, 1'b0, 1'b1, 1'b1);
    chk("irq_set", 32'(irq_n), 32'h0);
`endif

    // Random segments of held values with occasional resets and bus reads.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      logic rst_v, rd_v, ce_v;
      v   = tbl[$urandom_range(0, 3)];
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        rst_v = ($urandom_range(0, 59) == 0);
        rd_v  = ($urandom_range(0, 3) != 0);
        ce_v  = ($urandom_range(0, 3) != 0);
        cycle(v, rst_v, rd_v, ce_v);
      end
    end
    hold(8'h00, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
